sn_1r1w_clr_mem: RTL and testbench

Parametrised single-clock 1-read/1-write memory for neuron state and synapse tables. It extends the basic 1R1W array with five additions: per-lane write enables, a configurable read pipeline depth with a read-valid strobe, a defined read-during-write policy, out-of-range address protection, and a hardware clear engine. The clear engine fills every row with a programmable value after reset or on request from the network controller, so software never has to zero neuron state row by row.

---
 rtl/sn_1r1w_clr_mem.sv | 204 ++++++++++++++++++++
 tb/tb_sn_1r1w_clr_mem.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn_1r1w_clr_mem.sv
// ---------------------------------------------------------------------------
// sn_1r1w_clr_mem
//
// Single-clock 1-read / 1-write memory for neuron state and synapse tables.
// On top of a plain 1R1W array it provides:
//   - per-lane write enables
//   - a read pipeline of P_RD_STAGES (1..3) with a read-valid strobe
//   - a fixed read-during-write policy (new data or old data, P_BYPASS)
//   - out-of-range protection (writes dropped, reads return zero)
//   - a clear engine that fills every row with P_INIT_VAL after reset or on
//     a clr request, one row per cycle
//
// Ports:
//   clk     in   1              clock, everything on the rising edge
//   rst     in   1              synchronous active-high reset
//   clr     in   1              one-cycle request to re-run the clear engine
//   busy    out  1              high during reset/clear; accesses ignored
//   we      in   P_NUM_LANES    per-lane write enable
//   waddr   in   clog2(rows)    write row
//   wdata   in   P_DATA_WIDTH   write data
//   re      in   1              read request
//   raddr   in   clog2(rows)    read row
//   rdata   out  P_DATA_WIDTH   read data, held between results
//   rvalid  out  1              one-cycle pulse per read result
//
// FSM states:
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_CLEAR | clear engine writes P_INIT_VAL to row cnt each cycle;
//           | external reads/writes and clr are ignored
//   S_IDLE  | normal operation; clr restarts the clear engine
// ---------------------------------------------------------------------------
module sn_1r1w_clr_mem #(
    parameter int                      P_DATA_WIDTH = 21,
    parameter int                      P_NUM_ROWS   = 1000,
    parameter int                      P_NUM_LANES  = 1,
    parameter int                      P_RD_STAGES  = 1,
    parameter int                      P_BYPASS     = 1,
    parameter logic [P_DATA_WIDTH-1:0] P_INIT_VAL   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    output logic                          busy,
    input  logic [P_NUM_LANES-1:0]        we,
    input  logic [$clog2(P_NUM_ROWS)-1:0] waddr,
    input  logic [P_DATA_WIDTH-1:0]       wdata,
    input  logic                          re,
    input  logic [$clog2(P_NUM_ROWS)-1:0] raddr,
    output logic [P_DATA_WIDTH-1:0]       rdata,
    output logic                          rvalid
);

    localparam int AW = $clog2(P_NUM_ROWS);
    localparam int LW = P_DATA_WIDTH / P_NUM_LANES;

    // One extra bit so the row count itself is representable when
    // P_NUM_ROWS is a power of two.
    localparam logic [AW:0]   ROWS_EXT = (AW + 1)'(P_NUM_ROWS);
    localparam logic [AW-1:0] LAST_ROW = AW'(P_NUM_ROWS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     cnt_q;
    logic [AW-1:0]     cnt_d;

    logic [P_DATA_WIDTH-1:0] mem [P_NUM_ROWS];

    logic                      access_ok;
    logic                      waddr_ok;
    logic                      raddr_ok;
    logic [P_NUM_LANES-1:0]    wr_lanes;
    logic [P_DATA_WIDTH-1:0]   wmask;
    logic                      rd_acc;
    logic                      collide;
    logic [P_DATA_WIDTH-1:0]   rd_old;
    logic [P_DATA_WIDTH-1:0]   rd_row;

    logic [P_DATA_WIDTH-1:0]   pipe_data [P_RD_STAGES];
    logic [P_RD_STAGES-1:0]    pipe_vld;

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                if (cnt_q == LAST_ROW) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_IDLE: begin
                if (clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy      = rst | (state_q == S_CLEAR);
    assign access_ok = (state_q == S_IDLE) && !rst;

    // ------------------------------------------------------------------
    // Access qualification
    // ------------------------------------------------------------------
    assign waddr_ok = ({1'b0, waddr} < ROWS_EXT);
    assign raddr_ok = ({1'b0, raddr} < ROWS_EXT);

    // Out-of-range writes are dropped here, so they also never count as a
    // collision for the bypass path below.
    assign wr_lanes = (access_ok && waddr_ok) ? we : '0;
    assign rd_acc   = access_ok && re;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < P_NUM_LANES; i++) begin
            wmask[i*LW +: LW] = {LW{wr_lanes[i]}};
        end
    end

    // ------------------------------------------------------------------
    // Read port with read-during-write policy
    // ------------------------------------------------------------------
    assign rd_old  = raddr_ok ? mem[raddr] : '0;
    assign collide = raddr_ok && (raddr == waddr) && (|wr_lanes);

    always_comb begin
        rd_row = rd_old;
        if ((P_BYPASS != 0) && collide) begin
            rd_row = (rd_old & ~wmask) | (wdata & wmask);
        end
    end

    // ------------------------------------------------------------------
    // Storage: the clear engine and external writes are mutually exclusive
    // because wr_lanes is forced to zero outside S_IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem[cnt_q] <= P_INIT_VAL;
            end
            for (int i = 0; i < P_NUM_LANES; i++) begin
                if (wr_lanes[i]) begin
                    mem[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Each stage only loads when the stage feeding it holds
    // a valid result, so the last stage naturally holds rdata between
    // reads. A clr does not flush it; reads already accepted complete.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int s = 0; s < P_RD_STAGES; s++) begin
                pipe_data[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_data[0] <= rd_row;
            end
            for (int s = 1; s < P_RD_STAGES; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                if (pipe_vld[s-1]) begin
                    pipe_data[s] <= pipe_data[s-1];
                end
            end
        end
    end

    assign rdata  = pipe_data[P_RD_STAGES-1];
    assign rvalid = pipe_vld[P_RD_STAGES-1];

endmodule

// File: tb/tb_sn_1r1w_clr_mem.sv
// ---------------------------------------------------------------------------
// tb_sn_1r1w_clr_mem
//
// Two instances driven by the same stimulus:
//   dut_a: 3 lanes, 3 read stages, bypass on
//   dut_b: 3 lanes, 2 read stages, bypass off
// Both clear to 21'h0ABCD. Every rvalid pulse is logged with its cycle
// number and compared against hand-computed expected data and latency.
// ---------------------------------------------------------------------------
module tb_sn_1r1w_clr_mem;

    localparam int              DW   = 21;
    localparam int              AW   = 10;
    localparam int              NL   = 3;
    localparam logic [DW-1:0]   INIT = 21'h0ABCD;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic            re;
    logic [NL-1:0]   we;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic [DW-1:0]   wdata;

    logic            busy_a;
    logic            busy_b;
    logic            rvalid_a;
    logic            rvalid_b;
    logic [DW-1:0]   rdata_a;
    logic [DW-1:0]   rdata_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] qa_d[$];
    logic [DW-1:0] qb_d[$];
    int            qa_c[$];
    int            qb_c[$];
    logic [DW-1:0] ea_d[$];
    logic [DW-1:0] eb_d[$];
    int            ea_c[$];
    int            eb_c[$];

    sn_1r1w_clr_mem #(
        .P_DATA_WIDTH (DW),
        .P_NUM_ROWS   (1000),
        .P_NUM_LANES  (NL),
        .P_RD_STAGES  (3),
        .P_BYPASS     (1),
        .P_INIT_VAL   (INIT)
    ) dut_a (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .busy   (busy_a),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata_a),
        .rvalid (rvalid_a)
    );

    sn_1r1w_clr_mem #(
        .P_DATA_WIDTH (DW),
        .P_NUM_ROWS   (1000),
        .P_NUM_LANES  (NL),
        .P_RD_STAGES  (2),
        .P_BYPASS     (0),
        .P_INIT_VAL   (INIT)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .busy   (busy_b),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata_b),
        .rvalid (rvalid_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rvalid_a === 1'b1) begin
            qa_d.push_back(rdata_a);
            qa_c.push_back(cyc);
        end
        if (rvalid_b === 1'b1) begin
            qb_d.push_back(rdata_b);
            qb_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one read; cyc after the tick is the accepting edge.
    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] xa, input logic [DW-1:0] xb);
        re    = 1'b1;
        raddr = a;
        tick();
        ea_d.push_back(xa);
        ea_c.push_back(cyc + 2);
        eb_d.push_back(xb);
        eb_c.push_back(cyc + 1);
        re = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (6) tick();
        chk({tag, "_cnt_a"}, qa_d.size(), ea_d.size());
        for (int i = 0; i < qa_d.size() && i < ea_d.size(); i++) begin
            chk({tag, "_data_a"}, qa_d[i], ea_d[i]);
            chk({tag, "_lat_a"}, qa_c[i], ea_c[i]);
        end
        chk({tag, "_cnt_b"}, qb_d.size(), eb_d.size());
        for (int i = 0; i < qb_d.size() && i < eb_d.size(); i++) begin
            chk({tag, "_data_b"}, qb_d[i], eb_d[i]);
            chk({tag, "_lat_b"}, qb_c[i], eb_c[i]);
        end
        qa_d.delete(); qa_c.delete(); ea_d.delete(); ea_c.delete();
        qb_d.delete(); qb_c.delete(); eb_d.delete(); eb_c.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; re = 1'b0; we = '0;
        waddr = '0; raddr = '0; wdata = '0;
        repeat (3) tick();

        chk("rst_busy_a",   busy_a,   1'b1);
        chk("rst_busy_b",   busy_b,   1'b1);
        chk("rst_rvalid_a", rvalid_a, 1'b0);
        chk("rst_rvalid_b", rvalid_b, 1'b0);
        chk("rst_rdata_a",  rdata_a,  21'h0);
        chk("rst_rdata_b",  rdata_b,  21'h0);

        // Boot clear: busy must fall after exactly 1000 edges.
        rst = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("boot_busy_len", n, 1000);
        chk("boot_busy_b", busy_b, 1'b0);

        rd(10'd0,   INIT, INIT);
        rd(10'd500, INIT, INIT);
        rd(10'd999, INIT, INIT);
        drain("init");

        // Lane enables: clear lane 1 (bits 13:7) only.
        we = 3'b111; waddr = 10'd5; wdata = 21'h1FFFFF; tick();
        we = 3'b010; wdata = 21'h0; tick();
        we = 3'b000;
        rd(10'd5, 21'h1FC07F, 21'h1FC07F);
        drain("lane");

        // Read-during-write on row 7.
        we = 3'b111; waddr = 10'd7; wdata = 21'h55; tick();
        wdata = 21'h123;
        rd(10'd7, 21'h123, 21'h55);
        we = 3'b000;
        rd(10'd7, 21'h123, 21'h123);
        we = 3'b001; wdata = 21'h1FFFFF;
        rd(10'd7, 21'h17F, 21'h123);
        we = 3'b000;
        rd(10'd7, 21'h17F, 21'h17F);
        drain("coll");

        // Back-to-back pipelined reads.
        we = 3'b111;
        waddr = 10'd1; wdata = 21'h11111; tick();
        waddr = 10'd2; wdata = 21'h22222; tick();
        waddr = 10'd3; wdata = 21'h33333; tick();
        we = 3'b000;
        rd(10'd1, 21'h11111, 21'h11111);
        rd(10'd2, 21'h22222, 21'h22222);
        rd(10'd3, 21'h33333, 21'h33333);
        drain("pipe");
        chk("hold_a",   rdata_a,  21'h33333);
        chk("hold_b",   rdata_b,  21'h33333);
        chk("hold_rv_a", rvalid_a, 1'b0);

        // clr with a same-cycle write to row 10 and a same-cycle read.
        clr = 1'b1; we = 3'b111; waddr = 10'd10; wdata = 21'h01234;
        rd(10'd5, 21'h1FC07F, 21'h1FC07F);
        clr = 1'b0; we = 3'b000;
        chk("clr_busy_a", busy_a, 1'b1);
        n = 0;
        while (busy_a === 1'b1 && n < 2000) begin
            if (n == 4) begin
                we = 3'b111; waddr = 10'd10; wdata = 21'h00777;
                re = 1'b1;   raddr = 10'd3;
            end else begin
                we = 3'b000; re = 1'b0;
            end
            tick();
            n++;
        end
        we = 3'b000; re = 1'b0;
        chk("clr_busy_len", n, 1000);
        chk("clr_busy_b", busy_b, 1'b0);
        drain("clr_inflight");
        rd(10'd10, INIT, INIT);
        rd(10'd5,  INIT, INIT);
        rd(10'd3,  INIT, INIT);
        drain("clr");

        // Reset while reads are in flight.
        re = 1'b1; raddr = 10'd3; tick();
        raddr = 10'd5; rst = 1'b1; tick();
        re = 1'b0; rst = 1'b0;
        chk("mid_rst_rvalid_a", rvalid_a, 1'b0);
        chk("mid_rst_rvalid_b", rvalid_b, 1'b0);
        chk("mid_rst_rdata_a",  rdata_a,  21'h0);
        chk("mid_rst_rdata_b",  rdata_b,  21'h0);
        chk("mid_rst_busy",     busy_a,   1'b1);
        n = 0;
        while (busy_a === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("mid_rst_busy_len", n, 1000);
        drain("mid_rst");

        // Out-of-range write colliding with an out-of-range read.
        we = 3'b111; waddr = 10'd1000; wdata = 21'h15555;
        rd(10'd1000, 21'h0, 21'h0);
        we = 3'b000;
        rd(10'd1023, 21'h0, 21'h0);
        rd(10'd0,    INIT,  INIT);
        rd(10'd488,  INIT,  INIT);
        rd(10'd999,  INIT,  INIT);
        drain("oor");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
